// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: D = X - Y - Bi, computed DIGIT bits per clock
// through a ripple of full adders fed with the inverted subtrahend (X + ~Y + ~Bi).
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             V
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_digit_check
      $error("serial_subtractor: DIGIT must be a positive divisor of WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] r_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             xs;
  logic             ys;

  logic [DIGIT-1:0]       sum;
  logic                   cout;
  logic [WIDTH+DIGIT-1:0] r_cat;
  logic [WIDTH-1:0]       r_next;
  logic                   accept;
  logic                   last_step;

  // One digit of X + ~Y + carry.
  always_comb begin : chain
    logic c;
    logic ny;
    // NOTE: blocking assignments here model the ripple inside one cycle; c must update in loop order.
    c   = carry;
    sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      ny     = ~y_sr[i];
      sum[i] = x_sr[i] ^ ny ^ c;
      c      = (x_sr[i] & ny) | ((x_sr[i] ^ ny) & c);
    end
    cout = c;
  end

  // New sum digit enters at the MSB end; the oldest digits end up at the LSB end after N steps.
  assign r_cat     = {sum, r_sr};
  assign r_next    = r_cat[WIDTH+DIGIT-1:DIGIT];
  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (cnt == CW'(N - 1));

  // NOTE: all state is non-blocking so every register samples pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x_sr  <= '0;
      y_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      xs    <= 1'b0;
      ys    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      Bo    <= 1'b0;
      V     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            state <= RUN;
            x_sr  <= X;
            y_sr  <= Y;
            xs    <= X[WIDTH-1];
            ys    <= Y[WIDTH-1];
            carry <= ~Bi;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          x_sr  <= x_sr >> DIGIT;
          y_sr  <= y_sr >> DIGIT;
          r_sr  <= r_next;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            D     <= r_next;
            Bo    <= ~cout;
            V     <= (xs != ys) && (r_next[WIDTH-1] != xs);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle two's-complement subtractor; the inverse operation of the team's 32-bit combinational adder datapath.
- Computes D = X - Y - Bi by iterating DIGIT bits per clock through a full-adder chain that uses the add-with-inverted-operand identity X + ~Y + ~Bi.
- Trades latency for area: one DIGIT-wide chain instead of a full-width one.
- Used in the area-constrained datapath, for example as the iterative step engine of the planned restoring divider.

Parameters:
WIDTH, 32, operand and result width in bits.
DIGIT, 1, bits processed per clock; must divide WIDTH exactly. A non-divisor is a compile-time error.

Ports:
clk  input  1  rising-edge clock, single clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
X  input  WIDTH  minuend; captured on accepted start.
Y  input  WIDTH  subtrahend; captured on accepted start.
Bi  input  1  borrow in; captured on accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when the result becomes valid.
D  output  WIDTH  difference X - Y - Bi, modulo 2^WIDTH.
Bo  output  1  borrow out; 1 when unsigned X < Y + Bi.
V  output  1  signed overflow of the subtraction.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, D=0, Bo=0, V=0.
  - Internal shift registers, carry and counter are cleared.
  - Reset mid-operation aborts with no done pulse; the partial result is discarded.
- States and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after N = WIDTH/DIGIT digit steps.
  - DONE -> RUN if start=1; otherwise DONE -> IDLE. The DONE state lasts exactly one cycle.
- Accept (IDLE or DONE with start=1):
  - Latch X, Y and the sign bits X[WIDTH-1], Y[WIDTH-1].
  - Set carry = ~Bi and counter = 0.
  - busy=1 from the next cycle.
- RUN, each cycle:
  - Low DIGIT bits of the X and Y shift registers plus carry go through a DIGIT-bit ripple of full adders, with the Y bits inverted.
  - The sum bits shift into the MSB end of the result shift register.
  - X and Y shift right by DIGIT.
  - carry takes the chain carry-out; counter increments.
- Completion (the edge where counter = N-1 in RUN):
  - The final digit is processed.
  - D is loaded with the full result.
  - Bo = ~final carry.
  - V = (Xs != Ys) and (D[WIDTH-1] != Xs), using the latched sign bits Xs and Ys.
  - busy goes to 0 and done goes to 1 for that following cycle (state DONE).
- Timing:
  - Latency: done is high in the cycle N clocks after the accept edge.
  - busy is high for exactly N cycles.
  - Back-to-back operation: start during the DONE cycle is accepted, giving a throughput of one result per N+1 cycles.
- Output stability: D, Bo and V change only at completion or reset. They hold their last result through IDLE and through the following operation.
- start while busy=1 is ignored, with no effect on operands or timing.
- X, Y and Bi may change freely after the accept edge.
- Arithmetic:
  - Fully modulo 2^WIDTH.
  - Y = 0 with Bi = 0 gives D = X, Bo = 0.
  - X = Y with Bi = 1 gives D = all-ones, Bo = 1.

Test Plan:
- WIDTH=32, DIGIT=1: X=5, Y=3, Bi=0 -> done exactly 32 clocks after accept; D=0x00000002, Bo=0, V=0; busy high for 32 cycles.
- X=3, Y=5, Bi=0 -> D=0xFFFFFFFE, Bo=1, V=0. Then X=10, Y=3, Bi=1 -> D=0x00000006, Bo=0.
- X=0x80000000, Y=1 -> D=0x7FFFFFFF, V=1, Bo=0. Then X=0x7FFFFFFF, Y=0xFFFFFFFF -> D=0x80000000, V=1, Bo=1.
- start pulsed again at cycles 5 and 20 of RUN with different X/Y -> ignored; result matches the first operands. start held high through DONE -> a second operation starts immediately, and its done arrives N+1 cycles after the first done.
- rst=1 at cycle 10 of RUN -> next cycle busy=0, done=0, D=0, Bo=0, V=0; no done pulse follows. A new start then completes normally.
- DIGIT=4 (N=8) and DIGIT=32 (N=1): 500 random X/Y/Bi vectors -> D, Bo and V match a reference model. Latency is exactly 8 cycles and 1 cycle respectively.
